// File: rtl/pdm_pkg.sv
// Shared state encoding and default sizing for the PDM microphone front end.
package pdm_pkg;

    localparam int DEF_SAMPLE_DEPTH = 16;
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_DECIMATION   = 64;
    localparam int DEF_WARMUP_BITS  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } pdm_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone bit clock and capture strobe generator; one instance per mic channel.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic mic_clk_o,
    output logic pdm_capture_o
);

    localparam int               DIV_W    = cntWidth(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             micClk_q, micClk_d;
    logic             capture_q, capture_d;

    // Both outputs are decoded from the current phase and registered, so the pad
    // clock and the strobe leave flops and drop together the cycle run_i falls.
    always_comb begin
        divCnt_d  = '0;
        micClk_d  = 1'b0;
        capture_d = 1'b0;
        if (run_i) begin
            divCnt_d  = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
            micClk_d  = (divCnt_q >= DIV_HALF);
            capture_d = (divCnt_q == DIV_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divCnt_q  <= '0;
            micClk_q  <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            divCnt_q  <= divCnt_d;
            micClk_q  <= micClk_d;
            capture_q <= capture_d;
        end
    end

    assign mic_clk_o     = micClk_q;
    assign pdm_capture_o = capture_q;

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone sequencer: wake-up interval, decimation scheduling and the
// valid/ready audio output register with saturating overrun accounting.
module pdm_mic_ctrl
    import pdm_pkg::*;
#(
    parameter int SAMPLE_DEPTH = DEF_SAMPLE_DEPTH,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int DECIMATION   = DEF_DECIMATION,
    parameter int WARMUP_BITS  = DEF_WARMUP_BITS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    output logic                    mic_clk_o,
    output logic                    pdm_capture_o,
    input  logic [SAMPLE_DEPTH-1:0] filt_sample_i,
    output logic [SAMPLE_DEPTH-1:0] audio_o,
    output logic                    audio_valid_o,
    input  logic                    audio_ready_i,
    output logic [7:0]              overrun_count_o,
    output logic [1:0]              state_o
);

    localparam int                WARM_W    = cntWidth(WARMUP_BITS);
    localparam int                DEC_W     = cntWidth(DECIMATION);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIMATION - 1);

    pdm_state_e               state_q, state_d;
    logic                     inWarmup, inRun, running;
    logic                     micClk, capture;
    logic [WARM_W-1:0]        warmCnt_q, warmCnt_d;
    logic [DEC_W-1:0]         decCnt_q, decCnt_d;
    logic                     due_q, due_d;
    logic [SAMPLE_DEPTH-1:0]  audio_q, audio_d;
    logic                     valid_q, valid_d;
    logic [7:0]               overrun_q, overrun_d;

    pdm_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) uClkGen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (running),
        .mic_clk_o     (micClk),
        .pdm_capture_o (capture)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping enable wins from every state; the unused encoding behaves as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARMUP: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (capture && (warmCnt_q == WARM_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = enable_i ? ST_WARMUP : ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inWarmup = enable_i && (state_q == ST_WARMUP);
        inRun    = enable_i && (state_q == ST_RUN);
        running  = inWarmup || inRun;
    end

    always_comb begin
        warmCnt_d = '0;
        decCnt_d  = '0;
        due_d     = 1'b0;
        if (inWarmup) begin
            warmCnt_d = warmCnt_q;
            if (capture) begin
                warmCnt_d = (warmCnt_q == WARM_LAST) ? '0 : warmCnt_q + WARM_W'(1);
            end
        end
        if (inRun) begin
            decCnt_d = decCnt_q;
            if (capture) begin
                decCnt_d = (decCnt_q == DEC_LAST) ? '0 : decCnt_q + DEC_W'(1);
                due_d    = (decCnt_q == DEC_LAST);
            end
        end
    end

    // due_q marks the cycle in which the filter output for the due capture is
    // valid; a load that finds an unconsumed sample overwrites it and counts.
    always_comb begin
        audio_d   = audio_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (!running) begin
            valid_d = 1'b0;
        end else if (due_q) begin
            audio_d = filt_sample_i;
            valid_d = 1'b1;
            if (valid_q && !audio_ready_i && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (valid_q && audio_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            warmCnt_q <= '0;
            decCnt_q  <= '0;
            due_q     <= 1'b0;
            audio_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 8'd0;
        end else begin
            warmCnt_q <= warmCnt_d;
            decCnt_q  <= decCnt_d;
            due_q     <= due_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign mic_clk_o       = micClk;
    assign pdm_capture_o   = capture;
    assign audio_o         = audio_q;
    assign audio_valid_o   = valid_q;
    assign overrun_count_o = overrun_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Scoreboard bench for pdm_mic_ctrl: a cycle-index reference model predicts the
// strobe schedule and the presented samples; a negedge monitor compares them.
module tb_pdm_mic_ctrl;

    localparam int SD  = 16;
    localparam int CD  = 4;
    localparam int DEC = 4;
    localparam int WB  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          audio_ready;
    logic [SD-1:0] filt_sample;
    logic          mic_clk;
    logic          pdm_capture;
    logic [SD-1:0] audio;
    logic          audio_valid;
    logic [7:0]    overrun_count;
    logic [1:0]    state;

    always #5 clk = ~clk;

    pdm_mic_ctrl #(
        .SAMPLE_DEPTH(SD),
        .CLK_DIV     (CD),
        .DECIMATION  (DEC),
        .WARMUP_BITS (WB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .mic_clk_o      (mic_clk),
        .pdm_capture_o  (pdm_capture),
        .filt_sample_i  (filt_sample),
        .audio_o        (audio),
        .audio_valid_o  (audio_valid),
        .audio_ready_i  (audio_ready),
        .overrun_count_o(overrun_count),
        .state_o        (state)
    );

    int            nChecks    = 0;
    int            nFails     = 0;
    int            nTransfers = 0;
    bit            monOn      = 1'b0;
    logic [SD-1:0] rampVal    = '0;

    logic [SD-1:0] expQ[$];
    int            t        = 0;
    bit            slotFull = 1'b0;
    int            expOvr   = 0;
    bit            expMic   = 1'b0;
    bit            expCap   = 1'b0;
    logic [1:0]    expState = 2'd0;

    // Cycle k counts from the first cycle spent in WARMUP; captures fall on
    // multiples of CD, the first WB are warm-up and every DEC-th after is due.
    function automatic bit isDue(input int k);
        int j;
        if (k < 1 || (k % CD) != 0) return 1'b0;
        j = k / CD;
        return (j > WB) && (((j - WB) % DEC) == 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles, input bit r, input bit en, input int readyMode, input bit ramp);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            rst    = r;
            enable = en;
            case (readyMode)
                0:       audio_ready = 1'b0;
                1:       audio_ready = 1'b1;
                default: audio_ready = 1'($urandom_range(0, 1));
            endcase
            if (ramp) begin
                rampVal++;
                filt_sample = rampVal;
            end else begin
                filt_sample = 16'($urandom);
            end
        end
    endtask

    task automatic checkResetState();
        @(negedge clk);
        checkOutput("rst_audio", 32'(audio), 32'd0);
        checkOutput("rst_valid", 32'(audio_valid), 32'd0);
        checkOutput("rst_overrun", 32'(overrun_count), 32'd0);
        checkOutput("rst_mic_clk", 32'(mic_clk), 32'd0);
        checkOutput("rst_capture", 32'(pdm_capture), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
    endtask

    // Reference model: advances on the edge using only the bench's own stimulus.
    always @(posedge clk) begin
        int k;
        if (rst) begin
            t        = 0;
            slotFull = 1'b0;
            expOvr   = 0;
            expQ.delete();
        end else if (!enable) begin
            t        = 0;
            slotFull = 1'b0;
            expQ.delete();
        end else begin
            if (t >= 2 && isDue(t - 2)) begin
                if (slotFull && !audio_ready) begin
                    expOvr = (expOvr < 255) ? expOvr + 1 : 255;
                    if (expQ.size() > 0) void'(expQ.pop_back());
                end
                expQ.push_back(filt_sample);
                slotFull = 1'b1;
            end else if (slotFull && audio_ready) begin
                slotFull = 1'b0;
            end
            t++;
        end
        if (t == 0) begin
            expState = 2'd0;
            expMic   = 1'b0;
            expCap   = 1'b0;
        end else begin
            k        = t - 1;
            expMic   = (k >= 1) && (((k - 1) % CD) >= (CD / 2));
            expCap   = (k >= 1) && ((k % CD) == 0);
            expState = (k >= CD * WB + 1) ? 2'd2 : 2'd1;
        end
    end

    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("state", 32'(state), 32'(expState));
            checkOutput("mic_clk", 32'(mic_clk), 32'(expMic));
            checkOutput("pdm_capture", 32'(pdm_capture), 32'(expCap));
            checkOutput("audio_valid", 32'(audio_valid), 32'(slotFull));
            checkOutput("overrun_count", 32'(overrun_count), 32'(expOvr));
            if (audio_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("audio_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("audio", 32'(audio), 32'(expQ[0]));
                    if (audio_ready) begin
                        void'(expQ.pop_front());
                        nTransfers++;
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        audio_ready = 1'b0;
        filt_sample = '0;
        applyStimulus(3, 1'b1, 1'b0, 0, 1'b0);
        monOn = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 0, 1'b0);
        checkResetState();

        applyStimulus(300, 1'b0, 1'b1, 1, 1'b1);
        applyStimulus(48, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(40, 1'b0, 1'b1, 1, 1'b0);
        applyStimulus(800, 1'b0, 1'b1, 2, 1'b0);

        applyStimulus(40, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(10, 1'b0, 1'b0, 2, 1'b0);
        applyStimulus(200, 1'b0, 1'b1, 2, 1'b0);

        applyStimulus(16 * 310, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        checkOutput("overrun_saturated", 32'(overrun_count), 32'd255);
        applyStimulus(20, 1'b0, 1'b1, 1, 1'b0);

        applyStimulus(1, 1'b1, 1'b1, 1, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 1, 1'b0);
        checkResetState();
        applyStimulus(300, 1'b0, 1'b1, 2, 1'b0);

        @(negedge clk);
        checkOutput("transfers_seen", 32'(nTransfers > 40), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
